bram_copy_ctrl: RTL
===================

Name: bram_copy_ctrl

Overview:
- Sequencer that copies a block of 32-bit words from a source BRAM port to a destination BRAM port.
- Issues byte-addressed reads (stride 4) to the source and tracks the fixed source read latency.
- Issues full-word writes (WE=4'b1111) to the destination at the matching address offset.
- Sits between a software-visible start/length/base register set and two my_bram-style BRAM ports; replaces ad-hoc delayed-address chaining in benches and top-level glue.

Parameters:
- BRAM_ADDR_WIDTH, 15, byte-address width of both BRAM ports.
- LEN_WIDTH, 14, width of word-count input; max copy = 2^LEN_WIDTH-1 words.
- RD_LATENCY, 2, cycles from SRC_ADDR/SRC_EN presented to SRC_RDDATA valid; legal range 1..4.

Ports:
- BRAM_CLK  in  1  single clock for the block and both BRAM ports.
- BRAM_RSTN  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- src_base  in  BRAM_ADDR_WIDTH  source start byte address; bits [1:0] ignored (treated 0); captured on accepted start.
- dst_base  in  BRAM_ADDR_WIDTH  destination start byte address; bits [1:0] ignored; captured on accepted start.
- len  in  LEN_WIDTH  word count; captured on accepted start.
- busy  out  1  high from cycle after accepted start until done pulse.
- done  out  1  1-cycle completion pulse.
- SRC_ADDR  out  BRAM_ADDR_WIDTH  source read address, registered.
- SRC_EN  out  1  source enable, registered.
- SRC_RDDATA  in  32  source read data.
- DST_ADDR  out  BRAM_ADDR_WIDTH  destination address, registered.
- DST_EN  out  1  destination enable, registered.
- DST_WE  out  4  destination byte write enables: 4'b1111 when writing, else 4'b0000.
- DST_WRDATA  out  32  destination write data, registered.
- csum  out  32  running checksum; present only with BRAM_COPY_CSUM_EN.

Behaviour:
- Reset (async, BRAM_RSTN=0): state=IDLE; busy, done, SRC_EN, DST_EN = 0; DST_WE=0; SRC_ADDR, DST_ADDR, DST_WRDATA, csum = 0; valid pipeline cleared.
- Reset mid-copy: abort immediately. No further writes. No done pulse. Destination holds a partial copy.
- States:
  - IDLE: on start=1 go to READ (len!=0) or FLUSH (len==0). Capture bases with bits [1:0] forced to 0.
  - READ: SRC_EN=1 for exactly len cycles. Read k (k=0..len-1) has SRC_ADDR=src_base+4k. Then go to DRAIN.
  - DRAIN: wait until the valid pipeline (depth RD_LATENCY+1) is empty, then go to FLUSH.
  - FLUSH: done=1 for one cycle, busy=0 in that cycle, then go to IDLE.
- Timing, with accepted start at cycle 0:
  - Read k is presented at cycle k+1.
  - SRC_RDDATA for read k is sampled at the end of cycle k+1+RD_LATENCY.
  - Write k is presented at cycle k+2+RD_LATENCY: DST_EN=1, DST_WE=4'hF, DST_ADDR=dst_base+4k, DST_WRDATA=sampled word.
  - done occurs at cycle len+2+RD_LATENCY.
  - len=0: done at cycle 1; no SRC_EN or DST_EN activity.
- Throughput: one word per cycle, no bubbles.
- Address arithmetic is modulo 2^BRAM_ADDR_WIDTH; addresses wrap silently past the top of memory.
- start while busy or in FLUSH is ignored; no queueing.
- Overlapping src/dst ranges are not checked. Copy order is ascending addresses.
- SRC_ADDR and DST_ADDR hold their last value when the corresponding enable is low.

Optional Feature:
- Macro: BRAM_COPY_CSUM_EN.
- Defined:
  - csum clears to 0 on accepted start.
  - On each write cycle, csum <= csum + DST_WRDATA, modulo 2^32.
  - csum is stable and final when done pulses; it holds until the next accepted start.
- Undefined: csum port and adder are absent.

Decomposition:
- Package bram_copy_pkg:
  - state enum {IDLE, READ, DRAIN, FLUSH};
  - WORD_BYTES=4;
  - WE_FULL=4'b1111;
  - DATA_WIDTH=32.
- Sub-module bram_copy_vpipe: a RD_LATENCY+1 stage shift register carrying {valid, dst_addr}. Reset clears all valid bits.

Test Plan:
- Basic copy: src preloaded 0x1000+k; start with src_base=0, dst_base=0x100, len=8, RD_LATENCY=2 -> dst[0x100+4k]=0x1000+k for k=0..7; done at cycle 12; busy high for cycles 1..11.
- len=0 -> done at cycle 1; zero SRC_EN/DST_EN cycles; dst unchanged.
- Wrap: src_base=0x7FF8, len=4 -> reads at 0x7FF8, 0x7FFC, 0x0000, 0x0004; writes in the same order at the dst offsets.
- start pulsed again at cycle 3 of a len=8 copy -> ignored; exactly 8 writes; one done pulse.
- BRAM_RSTN low at cycle 5 of a len=8 copy -> outputs go to 0 immediately; only writes k<=0 issued (write 0 at cycle 4); no done pulse; new start after reset completes normally.
- With BRAM_COPY_CSUM_EN: words 1..8 copied -> csum=36 at done; a second copy of all 0xFFFFFFFF, len=2 -> csum=0xFFFFFFFE.

Source files
------------

// File: rtl/bram_copy_pkg.sv
// Shared types and constants for the BRAM block-copy sequencer.
//   state_t    : sequencer states
//   WORD_BYTES : byte stride between consecutive 32-bit words
//   WE_FULL    : full-word byte write enable
//   DATA_WIDTH : BRAM data width
package bram_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [3:0]  WE_FULL    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FLUSH
  } state_t;

endpackage

// File: rtl/bram_copy_vpipe.sv
// Valid/address delay line that follows each source read until its data
// returns, so the matching destination write can be issued.
//   clk, rst_n : clock, async active-low reset (clears all valid bits)
//   in_valid   : a read is being issued to the source this cycle
//   in_addr    : destination byte address belonging to that read
//   out_valid  : last stage valid (source data is on SRC_RDDATA now)
//   out_addr   : destination address of the last stage
//   any_valid  : OR of all stage valid bits
module bram_copy_vpipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          any_valid
);

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    addr_q [DEPTH];

  // Shift register: stage 0 lines up with SRC_EN, last stage with read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= '0;
    end else begin
      vld[0]    <= in_valid;
      addr_q[0] <= in_addr;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld[i]    <= vld[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/bram_copy_ctrl.sv
// Block-copy sequencer: reads len words from a source BRAM port (fixed read
// latency RD_LATENCY, legal 1..4) and writes them to a destination BRAM port,
// one word per cycle, ascending addresses, modulo 2^BRAM_ADDR_WIDTH.
// Optional running checksum enabled with macro BRAM_COPY_CSUM_EN.
//   BRAM_CLK, BRAM_RSTN          : clock, async active-low reset
//   start, src_base, dst_base, len : copy request (sampled in IDLE only)
//   busy, done                   : status / 1-cycle completion pulse
//   SRC_ADDR, SRC_EN, SRC_RDDATA : source read port
//   DST_ADDR, DST_EN, DST_WE, DST_WRDATA : destination write port
//   csum                         : sum of written words (BRAM_COPY_CSUM_EN)
module bram_copy_ctrl
  import bram_copy_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned LEN_WIDTH       = 14,
  parameter int unsigned RD_LATENCY      = 2
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RSTN,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
  input  logic [BRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]       len,
  output logic                       busy,
  output logic                       done,
`ifdef BRAM_COPY_CSUM_EN
  output logic [DATA_WIDTH-1:0]      csum,
`endif
  output logic [BRAM_ADDR_WIDTH-1:0] SRC_ADDR,
  output logic                       SRC_EN,
  input  logic [DATA_WIDTH-1:0]      SRC_RDDATA,
  output logic [BRAM_ADDR_WIDTH-1:0] DST_ADDR,
  output logic                       DST_EN,
  output logic [3:0]                 DST_WE,
  output logic [DATA_WIDTH-1:0]      DST_WRDATA
);

  localparam int unsigned AW = BRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(WORD_BYTES - 1);
  localparam logic [AW-1:0] STRIDE     = AW'(WORD_BYTES);

  state_t                 state, state_d;
  logic [LEN_WIDTH-1:0]   rd_left, rd_left_d;
  logic [AW-1:0]          dst_ptr, dst_ptr_d;
  logic [AW-1:0]          src_addr_d, dst_addr_d, pipe_in_addr, pipe_out_addr;
  logic                   src_en_d, busy_d, done_d, dst_en_d;
  logic [3:0]             dst_we_d;
  logic [DATA_WIDTH-1:0]  dst_wrdata_d;
  logic                   pipe_out_valid, pipe_any;

  // Pipe is fed the next-cycle SRC_EN so its stage 0 coincides with the read
  bram_copy_vpipe #(
    .DEPTH (RD_LATENCY + 1),
    .AW    (AW)
  ) u_vpipe (
    .clk       (BRAM_CLK),
    .rst_n     (BRAM_RSTN),
    .in_valid  (src_en_d),
    .in_addr   (pipe_in_addr),
    .out_valid (pipe_out_valid),
    .out_addr  (pipe_out_addr),
    .any_valid (pipe_any)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    rd_left_d    = rd_left;
    dst_ptr_d    = dst_ptr;
    src_en_d     = 1'b0;
    src_addr_d   = SRC_ADDR;
    pipe_in_addr = dst_ptr;
    done_d       = 1'b0;
    dst_en_d     = pipe_out_valid;
    dst_we_d     = pipe_out_valid ? WE_FULL : 4'b0000;
    dst_addr_d   = pipe_out_valid ? pipe_out_addr : DST_ADDR;
    dst_wrdata_d = pipe_out_valid ? SRC_RDDATA : DST_WRDATA;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d      = READ;
            src_en_d     = 1'b1;
            src_addr_d   = src_base & ALIGN_MASK;
            rd_left_d    = len - LEN_WIDTH'(1);
            pipe_in_addr = dst_base & ALIGN_MASK;
            dst_ptr_d    = (dst_base & ALIGN_MASK) + STRIDE;
          end else begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_left != '0) begin
          src_en_d   = 1'b1;
          src_addr_d = SRC_ADDR + STRIDE;
          rd_left_d  = rd_left - LEN_WIDTH'(1);
          dst_ptr_d  = dst_ptr + STRIDE;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_any) begin
          state_d = FLUSH;
          done_d  = 1'b1;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == READ) || (state_d == DRAIN);
  end

  // State and registered outputs
  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      state      <= IDLE;
      rd_left    <= '0;
      dst_ptr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SRC_EN     <= 1'b0;
      SRC_ADDR   <= '0;
      DST_EN     <= 1'b0;
      DST_WE     <= 4'b0000;
      DST_ADDR   <= '0;
      DST_WRDATA <= '0;
    end else begin
      state      <= state_d;
      rd_left    <= rd_left_d;
      dst_ptr    <= dst_ptr_d;
      busy       <= busy_d;
      done       <= done_d;
      SRC_EN     <= src_en_d;
      SRC_ADDR   <= src_addr_d;
      DST_EN     <= dst_en_d;
      DST_WE     <= dst_we_d;
      DST_ADDR   <= dst_addr_d;
      DST_WRDATA <= dst_wrdata_d;
    end
  end

`ifdef BRAM_COPY_CSUM_EN
  // Running sum of written words; cleared on accepted start, final at done
  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (DST_EN) begin
      csum <= csum + DST_WRDATA;
    end
  end
`endif

endmodule
